// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the load/store unit state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Encodings with no RV32I load/store meaning; handled as word-size and always trapped.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/ready bus between the memory stage (master) and memory (slave).
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            DReq;
    logic            DWe;
    logic [XLEN-1:0] DAddr;
    logic [XLEN-1:0] DWData;
    logic [3:0]      DBe;
    logic            DReady;
    logic [XLEN-1:0] DRData;

    modport master (
        output DReq, DWe, DAddr, DWData, DBe,
        input  DReady, DRData
    );

    modport slave (
        input  DReq, DWe, DAddr, DWData, DBe,
        output DReady, DRData
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data replication and load extract/extend.
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rword_i,
    output logic [3:0]      st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] rshift;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    assign rshift = rword_i >> {addr_lo_i, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = rshift[15:0];

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_be_o    = 4'b0001 << addr_lo_i;
                st_wdata_o = {(XLEN/8){wdata_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = 4'b0011 << addr_lo_i;
                st_wdata_o = {(XLEN/16){wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data_o = rword_i;
        case (funct3_i)
            F3_B:    ld_data_o = {{(XLEN-8){rbyte[7]}}, rbyte};
            F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, rbyte};
            F3_H:    ld_data_o = {{(XLEN-16){rhalf[15]}}, rhalf};
            F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, rhalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: issues data-memory accesses, stalls while one is in flight, and holds MEM/WB.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_lsu_if.master   dmem,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [REG_AW-1:0] RdM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic              RegWriteM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    output logic              StallM,
    output logic              MisalignedM,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [REG_AW-1:0] RdW,
    output logic              RegWriteW
);

    lsu_state_t        state_q, state_d;
    logic              issue;
    logic              is_mem, access;
    logic [3:0]        st_be;
    logic [XLEN-1:0]   st_wdata, ld_data, read_data;

    logic              dwe_q;
    logic [3:0]        dbe_q;
    logic [XLEN-1:0]   daddr_q, dwdata_q, rdata_q;

    logic [XLEN-1:0]   alu_w_q, rdata_w_q, pc4_w_q;
    logic [REG_AW-1:0] rd_w_q;
    logic              regwrite_w_q;

    assign is_mem      = MemReadM | MemWriteM;
    assign MisalignedM = is_mem & (f3_illegal(Funct3M)
                                   | ((Funct3M[1:0] == 2'b01) & ALUResultM[0])
                                   | ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00)));
    assign access      = is_mem & ~MisalignedM;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr_lo_i  (ALUResultM[1:0]),
        .funct3_i   (Funct3M),
        .wdata_i    (WriteDataM),
        .rword_i    (rdata_q),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        StallM  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (access) begin
                state_d = BUSY;
                StallM  = 1'b1;
                issue   = 1'b1;
            end
            BUSY: begin
                StallM = 1'b1;
                if (dmem.DReady) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request fields are latched at issue so the bus stays stable for the whole wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwe_q    <= 1'b0;
            dbe_q    <= 4'b0000;
            daddr_q  <= '0;
            dwdata_q <= '0;
            rdata_q  <= '0;
        end else if (issue) begin
            dwe_q    <= MemWriteM;
            dbe_q    <= MemWriteM ? st_be : 4'b1111;
            daddr_q  <= {ALUResultM[XLEN-1:2], 2'b00};
            dwdata_q <= MemWriteM ? st_wdata : '0;
        end else if ((state_q == BUSY) && dmem.DReady) begin
            dwe_q   <= 1'b0;
            dbe_q   <= 4'b0000;
            rdata_q <= dmem.DRData;
        end
    end

    assign dmem.DReq   = (state_q == BUSY);
    assign dmem.DWe    = dwe_q;
    assign dmem.DBe    = dbe_q;
    assign dmem.DAddr  = daddr_q;
    assign dmem.DWData = dwdata_q;

    // Store wins when both read and write are set, so only a pure load returns data.
    assign read_data = ((state_q == DONE) && MemReadM && !MemWriteM) ? ld_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_w_q      <= '0;
            rdata_w_q    <= '0;
            pc4_w_q      <= '0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
        end else if (!StallM) begin
            alu_w_q      <= ALUResultM;
            rdata_w_q    <= read_data;
            pc4_w_q      <= PCPlus4M;
            rd_w_q       <= RdM;
            regwrite_w_q <= RegWriteM & ~MisalignedM;
        end else begin
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
        end
    end

    assign ALUResultW = alu_w_q;
    assign ReadDataW  = rdata_w_q;
    assign PCPlus4W   = pc4_w_q;
    assign RdW        = rd_w_q;
    assign RegWriteW  = regwrite_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: plays EX/MEM and a variable-latency data memory.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic        StallM, MisalignedM, RegWriteW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    mem_stage_lsu_if #(.XLEN(32)) dmem ();

    mem_stage_lsu #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .dmem        (dmem),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .RdM         (RdM),
        .PCPlus4M    (PCPlus4M),
        .RegWriteM   (RegWriteM),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .Funct3M     (Funct3M),
        .StallM      (StallM),
        .MisalignedM (MisalignedM),
        .ALUResultW  (ALUResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .RdW         (RdW),
        .RegWriteW   (RegWriteW)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Observations of the most recent instruction, filled in by run_instr.
    int          stalls, req_cycles, episodes;
    logic        mis_first, req_at_retire;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_addr;
    logic        last_we;

    task automatic drive_nop();
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        RegWriteM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = F3_W;
    endtask

    // Entered and left at a falling edge; holds inputs while StallM is high.
    task automatic run_instr(input logic rw, input logic rd_en, input logic wr_en,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] rd,
                             input int waits, input logic [31:0] rword);
        int   cnt;
        logic prev, stl, retired;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = addr + 32'd4;
        RegWriteM = rw; MemReadM = rd_en; MemWriteM = wr_en; Funct3M = f3;
        stalls = 0; req_cycles = 0; episodes = 0; cnt = 0;
        prev = 1'b0; retired = 1'b0; req_at_retire = 1'b0; mis_first = 1'b0;
        for (int c = 0; c < 64 && !retired; c++) begin
            #1;
            if (c == 0) mis_first = MisalignedM;
            if (dmem.DReq) begin
                req_cycles++;
                if (!prev) episodes++;
                last_be = dmem.DBe; last_wdata = dmem.DWData;
                last_addr = dmem.DAddr; last_we = dmem.DWe;
                dmem.DReady = (cnt == waits);
                dmem.DRData = (cnt == waits) ? rword : 32'h0;
                cnt++;
            end
            prev = dmem.DReq;
            stl  = StallM;
            if (stl) stalls++;
            else     req_at_retire = dmem.DReq;
            @(posedge clk);
            @(negedge clk);
            dmem.DReady = 1'b0;
            if (!stl) retired = 1'b1;
        end
        if (!retired) check("retire_timeout", 32'd0, 32'd1);
        drive_nop();
    endtask

    initial begin
        dmem.DReady = 1'b0;
        dmem.DRData = '0;
        drive_nop();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_dreq",     dmem.DReq,  0);
        check("rst_dbe",      dmem.DBe,   0);
        check("rst_dwe",      dmem.DWe,   0);
        check("rst_regwrite", RegWriteW,  0);
        check("rst_aluw",     ALUResultW, 0);
        check("rst_readw",    ReadDataW,  0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: ALU-type pass-through
        run_instr(1, 0, 0, 3'b011, 32'h1234, 32'h0, 5'd5, 0, 0);
        check("alu_stalls",   stalls,     0);
        check("alu_reqs",     req_cycles, 0);
        check("alu_mis",      mis_first,  0);
        check("alu_aluw",     ALUResultW, 32'h1234);
        check("alu_rdw",      RdW,        5);
        check("alu_regwrite", RegWriteW,  1);
        check("alu_pc4w",     PCPlus4W,   32'h1238);
        check("alu_readw",    ReadDataW,  0);

        // 2: LB / LBU at byte lane 3, zero-wait memory
        run_instr(1, 1, 0, F3_B, 32'h103, 32'h0, 5'd6, 0, 32'h80FF_FFFF);
        check("lb_stalls", stalls,     2);
        check("lb_reqs",   req_cycles, 1);
        check("lb_be",     last_be,    4'b1111);
        check("lb_addr",   last_addr,  32'h100);
        check("lb_data",   ReadDataW,  32'hFFFF_FF80);
        check("lb_rdw",    RdW,        6);
        check("lb_rw",     RegWriteW,  1);
        run_instr(1, 1, 0, F3_BU, 32'h103, 32'h0, 5'd6, 0, 32'h80FF_FFFF);
        check("lbu_data",  ReadDataW,  32'h0000_0080);

        // LH / LHU on the upper half
        run_instr(1, 1, 0, F3_H, 32'h102, 32'h0, 5'd8, 1, 32'h8001_1234);
        check("lh_stalls", stalls,    3);
        check("lh_data",   ReadDataW, 32'hFFFF_8001);
        run_instr(1, 1, 0, F3_HU, 32'h102, 32'h0, 5'd8, 0, 32'h8001_1234);
        check("lhu_data",  ReadDataW, 32'h0000_8001);

        // 3: SH at 0x102 with three wait cycles
        run_instr(0, 0, 1, F3_H, 32'h102, 32'h0000_ABCD, 5'd0, 3, 0);
        check("sh_stalls",   stalls,        5);
        check("sh_reqs",     req_cycles,    4);
        check("sh_be",       last_be,       4'b1100);
        check("sh_wdata",    last_wdata,    32'hABCD_ABCD);
        check("sh_addr",     last_addr,     32'h100);
        check("sh_we",       last_we,       1);
        check("sh_done_req", req_at_retire, 0);
        check("sh_rw",       RegWriteW,     0);

        // SB lane 1, plus read-and-write together acting as a store
        run_instr(0, 1, 1, F3_B, 32'h101, 32'h1234_565A, 5'd0, 0, 32'hFFFF_FFFF);
        check("sb_be",    last_be,    4'b0010);
        check("sb_wdata", last_wdata, 32'h5A5A_5A5A);
        check("sb_we",    last_we,    1);
        check("sb_readw", ReadDataW,  0);

        // 4: misaligned LW and illegal funct3
        run_instr(1, 1, 0, F3_W, 32'h101, 32'h0, 5'd9, 0, 0);
        check("mis_flag",   mis_first,  1);
        check("mis_stalls", stalls,     0);
        check("mis_reqs",   req_cycles, 0);
        check("mis_rw",     RegWriteW,  0);
        run_instr(1, 1, 0, 3'b110, 32'h100, 32'h0, 5'd9, 0, 0);
        check("ill_flag",   mis_first,  1);
        check("ill_reqs",   req_cycles, 0);

        // 5: reset while BUSY
        run_instr(1, 0, 0, F3_W, 32'h55, 32'h0, 5'd7, 0, 0);
        ALUResultM = 32'h200; RdM = 5'd3; RegWriteM = 1'b1; MemReadM = 1'b1; Funct3M = F3_W;
        @(posedge clk);
        @(negedge clk);
        check("busy_dreq", dmem.DReq, 1);
        reset = 1'b1;
        #1;
        check("rstbusy_dreq", dmem.DReq,  0);
        check("rstbusy_aluw", ALUResultW, 0);
        check("rstbusy_rdw",  RdW,        0);
        check("rstbusy_rw",   RegWriteW,  0);
        drive_nop();
        @(negedge clk);
        reset = 1'b0;
        dmem.DReady = 1'b1;
        dmem.DRData = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("ignore_dreq",  dmem.DReq, 0);
        check("ignore_stall", StallM,    0);
        dmem.DReady = 1'b0;
        @(negedge clk);
        run_instr(1, 1, 0, F3_W, 32'h104, 32'h0, 5'd4, 0, 32'h1234_5678);
        check("post_rst_lw", ReadDataW, 32'h1234_5678);
        check("post_rst_stalls", stalls, 2);

        // 6: back-to-back LW then SW
        run_instr(1, 1, 0, F3_W, 32'h10C, 32'h0, 5'd10, 0, 32'hDEAD_BEEF);
        check("b2b_lw_ep",   episodes,      1);
        check("b2b_lw_done", req_at_retire, 0);
        check("b2b_lw_data", ReadDataW,     32'hDEAD_BEEF);
        run_instr(0, 0, 1, F3_W, 32'h108, 32'hCAFE_F00D, 5'd0, 1, 0);
        check("b2b_sw_ep",    episodes,      1);
        check("b2b_sw_done",  req_at_retire, 0);
        check("b2b_sw_be",    last_be,       4'b1111);
        check("b2b_sw_wdata", last_wdata,    32'hCAFE_F00D);
        check("b2b_sw_addr",  last_addr,     32'h108);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
